// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants for the clause-22 status poller.
//   - ST/OP codes, frame bit positions, speed encodings
//   - status register bit indices, FSM state encodings
//   - decode_status(): raw PHY status word -> link/speed/duplex
package mdio_pkg;
  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int PRE_END    = 31;
  localparam int TA_START   = 46;
  localparam int DATA_START = 48;
  localparam int LAST_BIT   = 63;

  localparam logic [1:0] SPD_10M   = 2'b00;
  localparam logic [1:0] SPD_100M  = 2'b01;
  localparam logic [1:0] SPD_1000M = 2'b10;

  localparam int ST_SPD_HI   = 15;
  localparam int ST_SPD_LO   = 14;
  localparam int ST_DUPLEX   = 13;
  localparam int ST_LINK     = 11;
  localparam int ST_RESOLVED = 10;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_PRE    = 3'd1;
  localparam state_t S_HDR    = 3'd2;
  localparam state_t S_TA     = 3'd3;
  localparam state_t S_DATA   = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam state_t S_PAUSED = 3'd6;

  typedef struct packed {
    logic       link_up;
    logic [1:0] speed;
    logic       full_duplex;
  } phy_status_t;

  // Speed code 11 is reserved; an absent PHY reads 0xFFFF and must not
  // look like a live link, so 11 forces link down.
  function automatic phy_status_t decode_status(input logic [15:0] d);
    phy_status_t s;
    s.link_up     = d[ST_LINK] & d[ST_RESOLVED] & (d[ST_SPD_HI:ST_SPD_LO] != 2'b11);
    s.speed       = s.link_up ? d[ST_SPD_HI:ST_SPD_LO] : SPD_10M;
    s.full_duplex = d[ST_DUPLEX] & s.link_up;
    return s;
  endfunction
endpackage

// File: rtl/mdio_status_poller_if.sv
// mdio_status_poller_if: MDIO pins, pause handshake and decoded status.
//   master modport: poller side; slave modport: PHY/selector side.
//   MDIO_POLL_INTR_EN adds phy_int (PHY interrupt, active-high).
interface mdio_status_poller_if;
  logic        pause_req;
  logic        pause_ack;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [15:0] reg_data;
  logic        status_valid;
  logic        link_up;
  logic [1:0]  speed;
  logic        full_duplex;
  logic        link_change;
`ifdef MDIO_POLL_INTR_EN
  logic        phy_int;

  modport master (input pause_req, mdio_i, phy_int,
                  output pause_ack, mdc, mdio_o, mdio_oe, reg_data, status_valid,
                         link_up, speed, full_duplex, link_change);
  modport slave  (output pause_req, mdio_i, phy_int,
                  input pause_ack, mdc, mdio_o, mdio_oe, reg_data, status_valid,
                        link_up, speed, full_duplex, link_change);
`else
  modport master (input pause_req, mdio_i,
                  output pause_ack, mdc, mdio_o, mdio_oe, reg_data, status_valid,
                         link_up, speed, full_duplex, link_change);
  modport slave  (output pause_req, mdio_i,
                  input pause_ack, mdc, mdio_o, mdio_oe, reg_data, status_valid,
                        link_up, speed, full_duplex, link_change);
`endif
endinterface

// File: rtl/mdio_status_poller_mdc_gen.sv
// mdc_gen: MDC divider. mdc toggles every CLK_DIV clk cycles while i_en=1,
// held low (counter cleared) otherwise.
//   i_en   : run the divider
//   o_mdc  : management clock
//   o_rise : high on the clk cycle whose edge drives mdc 0->1
//   o_fall : high on the clk cycle whose edge drives mdc 1->0
module mdc_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_mdc,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_mdc;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_mdc  = r_mdc;
  assign o_rise = w_wrap & ~r_mdc;
  assign o_fall = w_wrap &  r_mdc;
endmodule

// File: rtl/mdio_status_poller.sv
// mdio_status_poller: clause-22 MDIO master that reads one PHY status
// register every POLL_INTERVAL idle cycles and decodes link/speed/duplex.
//   clk, rst : system clock, async active-high reset
//   bus      : mdio_status_poller_if.master (MDIO pins, pause handshake,
//              reg_data/status_valid, decoded link_up/speed/full_duplex,
//              link_change pulse)
// Optional: MDIO_POLL_INTR_EN adds bus.phy_int; a synchronised rising edge
// starts a frame early (immediately from IDLE, right after DONE otherwise).
module mdio_status_poller
  import mdio_pkg::*;
#(
  parameter int         CLK_DIV       = 10,
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter logic [4:0] REG_ADDR      = 5'd17,
  parameter int         POLL_INTERVAL = 1000
) (
  input logic                  clk,
  input logic                  rst,
  mdio_status_poller_if.master bus
);
  localparam int IW = $clog2(POLL_INTERVAL + 1);
  // Header bits 32..45, MSB first; padded to 16 so a 4-bit index stays in range.
  localparam logic [15:0] HDR = {2'b00, MDIO_ST, MDIO_OP_RD, PHY_ADDR, REG_ADDR};

  state_t        r_state, w_nxt;
  logic [5:0]    r_bit;
  logic [IW-1:0] r_ivl;
  logic [15:0]   r_shift, r_reg;
  phy_status_t   r_stat, w_dec;
  logic          r_sv, r_chg;
  logic          w_en, w_mdc, w_rise, w_fall, w_kick;
  logic [3:0]    w_hdr_idx;

  assign w_en = (r_state == S_PRE) || (r_state == S_HDR) ||
                (r_state == S_TA)  || (r_state == S_DATA);

  mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .o_mdc  (w_mdc),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

`ifdef MDIO_POLL_INTR_EN
  logic [1:0] r_int_sync;
  logic       r_int_prev, r_int_pend;
  logic       w_int_edge, w_start;

  assign w_int_edge = r_int_sync[1] & ~r_int_prev;
  assign w_start    = (w_nxt == S_PRE) && (r_state != S_PRE);
  assign w_kick     = w_int_edge | r_int_pend;

  // Edges seen mid-frame or while paused are held until a frame starts;
  // any frame starting after the edge already reads the new status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_sync <= 2'b00;
      r_int_prev <= 1'b0;
      r_int_pend <= 1'b0;
    end else begin
      r_int_sync <= {r_int_sync[0], bus.phy_int};
      r_int_prev <= r_int_sync[1];
      r_int_pend <= (r_int_pend | w_int_edge) & ~w_start;
    end
  end
`else
  assign w_kick = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.pause_req)                    w_nxt = S_PAUSED;
                else if ((r_ivl == '0) || w_kick)     w_nxt = S_PRE;
      S_PRE:    if (w_fall && r_bit == 6'(PRE_END))        w_nxt = S_HDR;
      S_HDR:    if (w_fall && r_bit == 6'(TA_START - 1))   w_nxt = S_TA;
      S_TA:     if (w_fall && r_bit == 6'(DATA_START - 1)) w_nxt = S_DATA;
      S_DATA:   if (w_fall && r_bit == 6'(LAST_BIT))       w_nxt = S_DONE;
      S_DONE:   if (bus.pause_req)                    w_nxt = S_PAUSED;
                else if (w_kick)                      w_nxt = S_PRE;
                else                                  w_nxt = S_IDLE;
      S_PAUSED: if (!bus.pause_req)                   w_nxt = S_PRE;
      default:                                        w_nxt = S_IDLE;
    endcase
  end

  assign w_dec = decode_status(r_shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_ivl   <= '0;
      r_shift <= '0;
      r_reg   <= '0;
      r_stat  <= '0;
      r_sv    <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_sv    <= 1'b0;
      r_chg   <= 1'b0;
      // 6-bit counter wraps 63->0 on the last fall, ready for the next frame.
      if (w_fall) r_bit <= r_bit + 1'b1;
      if (r_state == S_IDLE && w_nxt == S_IDLE) r_ivl <= r_ivl - 1'b1;
      if (r_state == S_DONE) r_ivl <= IW'(POLL_INTERVAL - 1);
      if (w_rise && r_state == S_DATA) r_shift <= {r_shift[14:0], bus.mdio_i};
      // Results are registered on the edge entering DONE so they are
      // visible during the DONE cycle itself.
      if (w_nxt == S_DONE) begin
        r_reg  <= r_shift;
        r_stat <= w_dec;
        r_sv   <= 1'b1;
        r_chg  <= (w_dec != r_stat);
      end
    end
  end

  assign w_hdr_idx = 4'd13 - r_bit[3:0];

  assign bus.mdc          = w_mdc;
  assign bus.mdio_oe      = (r_state == S_PRE) || (r_state == S_HDR);
  assign bus.mdio_o       = (r_state == S_HDR) ? HDR[w_hdr_idx] : 1'b1;
  assign bus.pause_ack    = (r_state == S_PAUSED);
  assign bus.reg_data     = r_reg;
  assign bus.status_valid = r_sv;
  assign bus.link_up      = r_stat.link_up;
  assign bus.speed        = r_stat.speed;
  assign bus.full_duplex  = r_stat.full_duplex;
  assign bus.link_change  = r_chg;
endmodule
